cpu_control_unit: RTL and testbench

// Moore FSM sequencer that drives the CPU_EU datapath and ram7 control strobes.
// It runs fetch/decode/execute from the instruction register contents and the registered C/N/Z flags.
// It sits directly upstream of CPU_EU and replaces the hand-driven switches (adr_sel, S_Sel, pc_ld, pc_inc, ir_ld, W_En, mem_w_en).
// The IR format is IR[15:9] opcode, IR[8:6] WA, IR[5:3] RA, IR[2:0] SA (8-entry register file).

---
 rtl/cpu_control_unit.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Moore fetch/decode/execute sequencer for the CPU_EU datapath and ram7.
// Outputs are registered from the next state and the IR, so each strobe is stable for the whole state.
module cpu_control_unit #(
    parameter logic [6:0] HLT_OP       = 7'h7F,
    parameter bit         ILLEGAL_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        W_En,
    output logic        S_Sel,
    output logic        adr_sel,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic        mem_w_en,
    output logic [3:0]  FS,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic [3:0]  state
);

    localparam int unsigned OP_W  = 7;
    localparam int unsigned FS_W  = 4;
    localparam int unsigned REG_W = 3;
    localparam logic [FS_W-1:0] FS_PASS_S = FS_W'(1);

    typedef enum logic [3:0] {
        ST_RESET    = 4'h0,
        ST_FETCH    = 4'h1,
        ST_DECODE   = 4'h2,
        ST_ALU      = 4'h3,
        ST_LD       = 4'h4,
        ST_ST       = 4'h5,
        ST_LDI      = 4'h6,
        ST_JMP      = 4'h7,
        ST_BR_TAKE  = 4'h8,
        ST_BR_SKIP  = 4'h9,
        ST_HALT     = 4'hA,
        ST_ILLEGAL  = 4'hB
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] wa;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] sa;

    assign opcode = ir[15:9];
    assign wa     = ir[8:6];
    assign ra     = ir[5:3];
    assign sa     = ir[2:0];

    // C and N are carried for future conditional branches; only Z steers today.
    logic unused_flags;
    assign unused_flags = C ^ N;

    logic             nx_w_en;
    logic             nx_s_sel;
    logic             nx_adr_sel;
    logic             nx_pc_ld;
    logic             nx_pc_inc;
    logic             nx_ir_ld;
    logic             nx_mem_w_en;
    logic [FS_W-1:0]  nx_fs;
    logic [REG_W-1:0] nx_w_adr;
    logic [REG_W-1:0] nx_r_adr;
    logic [REG_W-1:0] nx_s_adr;

    // Next-state selection; flags are only consulted while in DECODE.
    always_comb begin
        nxt_state = ST_RESET;
        case (cur_state)
            ST_RESET:  nxt_state = ST_FETCH;
            ST_FETCH:  nxt_state = ST_DECODE;
            ST_DECODE: begin
                if (opcode <= 7'h0F) begin
                    nxt_state = ST_ALU;
                end else begin
                    case (opcode)
                        7'h10:   nxt_state = ST_LD;
                        7'h11:   nxt_state = ST_ST;
                        7'h12:   nxt_state = ST_LDI;
                        7'h13:   nxt_state = ST_JMP;
                        7'h14:   nxt_state = Z ? ST_BR_TAKE : ST_BR_SKIP;
                        7'h15:   nxt_state = Z ? ST_BR_SKIP : ST_BR_TAKE;
                        default: begin
                            if (opcode == HLT_OP) begin
                                nxt_state = ST_HALT;
                            end else if (ILLEGAL_TRAP) begin
                                nxt_state = ST_ILLEGAL;
                            end else begin
                                nxt_state = ST_FETCH;
                            end
                        end
                    endcase
                end
            end
            ST_ALU, ST_LD, ST_ST, ST_LDI, ST_JMP, ST_BR_TAKE, ST_BR_SKIP:
                nxt_state = ST_FETCH;
            ST_HALT:    nxt_state = ST_HALT;
            ST_ILLEGAL: nxt_state = ST_ILLEGAL;
            default:    nxt_state = ST_RESET;
        endcase
    end

    // Strobe decode for the state about to be entered.
    always_comb begin
        nx_w_en     = 1'b0;
        nx_s_sel    = 1'b0;
        nx_adr_sel  = 1'b0;
        nx_pc_ld    = 1'b0;
        nx_pc_inc   = 1'b0;
        nx_ir_ld    = 1'b0;
        nx_mem_w_en = 1'b0;
        nx_fs       = '0;
        nx_w_adr    = '0;
        nx_r_adr    = '0;
        nx_s_adr    = '0;
        case (nxt_state)
            ST_FETCH: begin
                nx_ir_ld  = 1'b1;
                nx_pc_inc = 1'b1;
            end
            ST_ALU: begin
                nx_fs    = ir[12:9];
                nx_w_adr = wa;
                nx_r_adr = ra;
                nx_s_adr = sa;
                nx_w_en  = 1'b1;
            end
            ST_LD: begin
                nx_adr_sel = 1'b1;
                nx_r_adr   = ra;
                nx_s_sel   = 1'b1;
                nx_fs      = FS_PASS_S;
                nx_w_adr   = wa;
                nx_w_en    = 1'b1;
            end
            ST_ST: begin
                nx_adr_sel  = 1'b1;
                nx_r_adr    = wa;
                nx_s_adr    = ra;
                nx_fs       = FS_PASS_S;
                nx_mem_w_en = 1'b1;
            end
            ST_LDI: begin
                nx_s_sel  = 1'b1;
                nx_fs     = FS_PASS_S;
                nx_w_adr  = wa;
                nx_w_en   = 1'b1;
                nx_pc_inc = 1'b1;
            end
            ST_JMP, ST_BR_TAKE: begin
                nx_pc_ld = 1'b1;
            end
            ST_BR_SKIP: begin
                nx_pc_inc = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_RESET;
            W_En      <= 1'b0;
            S_Sel     <= 1'b0;
            adr_sel   <= 1'b0;
            pc_ld     <= 1'b0;
            pc_inc    <= 1'b0;
            ir_ld     <= 1'b0;
            mem_w_en  <= 1'b0;
            FS        <= '0;
            W_Adr     <= '0;
            R_Adr     <= '0;
            S_Adr     <= '0;
        end else begin
            cur_state <= nxt_state;
            W_En      <= nx_w_en;
            S_Sel     <= nx_s_sel;
            adr_sel   <= nx_adr_sel;
            pc_ld     <= nx_pc_ld;
            pc_inc    <= nx_pc_inc;
            ir_ld     <= nx_ir_ld;
            mem_w_en  <= nx_mem_w_en;
            FS        <= nx_fs;
            W_Adr     <= nx_w_adr;
            R_Adr     <= nx_r_adr;
            S_Adr     <= nx_s_adr;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: instruction-level reference model feeds per-cycle expectations.
module tb_cpu_control_unit;

    typedef struct packed {
        logic [3:0] state;
        logic       w_en;
        logic       s_sel;
        logic       adr_sel;
        logic       pc_ld;
        logic       pc_inc;
        logic       ir_ld;
        logic       mem_w_en;
        logic [3:0] fs;
        logic [2:0] w_adr;
        logic [2:0] r_adr;
        logic [2:0] s_adr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: undefined opcodes trap.
    logic        reset = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        c_flag = 1'b0, n_flag = 1'b0, z_flag = 1'b0;
    logic        w_en1, s_sel1, adr_sel1, pc_ld1, pc_inc1, ir_ld1, mem_w_en1;
    logic [3:0]  fs1, state1;
    logic [2:0]  w_adr1, r_adr1, s_adr1;

    // Second instance: undefined opcodes behave as NOP.
    logic        reset2 = 1'b1;
    logic [15:0] ir2 = 16'h0000;
    logic        w_en2, s_sel2, adr_sel2, pc_ld2, pc_inc2, ir_ld2, mem_w_en2;
    logic [3:0]  fs2, state2;
    logic [2:0]  w_adr2, r_adr2, s_adr2;

    cpu_control_unit #(.HLT_OP(7'h7F), .ILLEGAL_TRAP(1'b1)) u_dut (
        .clk(clk), .reset(reset), .ir(ir), .C(c_flag), .N(n_flag), .Z(z_flag),
        .W_En(w_en1), .S_Sel(s_sel1), .adr_sel(adr_sel1), .pc_ld(pc_ld1), .pc_inc(pc_inc1),
        .ir_ld(ir_ld1), .mem_w_en(mem_w_en1), .FS(fs1), .W_Adr(w_adr1), .R_Adr(r_adr1),
        .S_Adr(s_adr1), .state(state1)
    );

    cpu_control_unit #(.HLT_OP(7'h7F), .ILLEGAL_TRAP(1'b0)) u_dut_nop (
        .clk(clk), .reset(reset2), .ir(ir2), .C(1'b0), .N(1'b0), .Z(1'b0),
        .W_En(w_en2), .S_Sel(s_sel2), .adr_sel(adr_sel2), .pc_ld(pc_ld2), .pc_inc(pc_inc2),
        .ir_ld(ir_ld2), .mem_w_en(mem_w_en2), .FS(fs2), .W_Adr(w_adr2), .R_Adr(r_adr2),
        .S_Adr(s_adr2), .state(state2)
    );

    exp_t q_main[$];
    exp_t q_nop[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   nop_done = 1'b0;

    // ---------------- reference model ----------------
    function automatic exp_t mk(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    function automatic exp_t fetch_e();
        exp_t e;
        e = mk(4'h1);
        e.ir_ld  = 1'b1;
        e.pc_inc = 1'b1;
        return e;
    endfunction

    // What the unit shows in the cycle after DECODE for instruction i.
    function automatic exp_t exec_e(input logic [15:0] i, input logic z, input bit trap);
        exp_t e;
        logic [6:0] op;
        logic [2:0] wa, ra, sa;
        op = i[15:9];
        wa = i[8:6];
        ra = i[5:3];
        sa = i[2:0];
        if (op == 7'h7F) begin
            e = mk(4'hA);
        end else if (op <= 7'h0F) begin
            e = mk(4'h3);
            e.fs = op[3:0]; e.w_adr = wa; e.r_adr = ra; e.s_adr = sa; e.w_en = 1'b1;
        end else if (op == 7'h10) begin
            e = mk(4'h4);
            e.adr_sel = 1'b1; e.r_adr = ra; e.s_sel = 1'b1; e.fs = 4'h1; e.w_adr = wa; e.w_en = 1'b1;
        end else if (op == 7'h11) begin
            e = mk(4'h5);
            e.adr_sel = 1'b1; e.r_adr = wa; e.s_adr = ra; e.fs = 4'h1; e.mem_w_en = 1'b1;
        end else if (op == 7'h12) begin
            e = mk(4'h6);
            e.s_sel = 1'b1; e.fs = 4'h1; e.w_adr = wa; e.w_en = 1'b1; e.pc_inc = 1'b1;
        end else if (op == 7'h13) begin
            e = mk(4'h7);
            e.pc_ld = 1'b1;
        end else if (op == 7'h14 || op == 7'h15) begin
            if ((op == 7'h14) == (z == 1'b1)) begin
                e = mk(4'h8);
                e.pc_ld = 1'b1;
            end else begin
                e = mk(4'h9);
                e.pc_inc = 1'b1;
            end
        end else begin
            e = trap ? mk(4'hB) : fetch_e();
        end
        return e;
    endfunction

    // ---------------- checking ----------------
    function automatic void check(input string name, input exp_t a, input exp_t e);
        vectors++;
        if (a !== e || (a.pc_ld && a.pc_inc) || (a.mem_w_en && a.w_en) ||
            (a.ir_ld && a.state != 4'h1)) begin
            miscompares++;
            $display("FAIL %s t=%0t got st=%h we=%b ss=%b as=%b pl=%b pi=%b il=%b mw=%b fs=%h wa=%0d ra=%0d sa=%0d | want st=%h we=%b ss=%b as=%b pl=%b pi=%b il=%b mw=%b fs=%h wa=%0d ra=%0d sa=%0d",
                     name, $time, a.state, a.w_en, a.s_sel, a.adr_sel, a.pc_ld, a.pc_inc, a.ir_ld,
                     a.mem_w_en, a.fs, a.w_adr, a.r_adr, a.s_adr, e.state, e.w_en, e.s_sel,
                     e.adr_sel, e.pc_ld, e.pc_inc, e.ir_ld, e.mem_w_en, e.fs, e.w_adr, e.r_adr, e.s_adr);
        end
    endfunction

    always @(negedge clk) begin
        if (q_main.size() > 0) begin
            exp_t a;
            a = '{state1, w_en1, s_sel1, adr_sel1, pc_ld1, pc_inc1, ir_ld1, mem_w_en1,
                  fs1, w_adr1, r_adr1, s_adr1};
            check("main", a, q_main.pop_front());
        end
    end

    always @(negedge clk) begin
        if (q_nop.size() > 0) begin
            exp_t a;
            a = '{state2, w_en2, s_sel2, adr_sel2, pc_ld2, pc_inc2, ir_ld2, mem_w_en2,
                  fs2, w_adr2, r_adr2, s_adr2};
            check("nop_variant", a, q_nop.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input exp_t e);
        @(posedge clk);
        #1;
        q_main.push_back(e);
    endtask

    task automatic cyc2(input exp_t e);
        @(posedge clk);
        #1;
        q_nop.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(mk(4'h0));
        reset = 1'b0;
        cyc(fetch_e());
    endtask

    // Called while the unit shows FETCH; leaves it showing FETCH again.
    task automatic run_instr(input logic [15:0] i, input logic z, input bit rst_mid, input int stop_cycles);
        ir     = i;
        z_flag = z;
        c_flag = 1'($urandom_range(0, 1));
        n_flag = 1'($urandom_range(0, 1));
        cyc(mk(4'h2));
        if (i[15:9] == 7'h7F || i[15:9] > 7'h15) begin
            repeat (stop_cycles) cyc(exec_e(i, z, 1'b1));
            do_reset();
        end else begin
            cyc(exec_e(i, z, 1'b1));
            z_flag = 1'($urandom_range(0, 1));
            if (rst_mid) do_reset();
            else cyc(fetch_e());
        end
    endtask

    initial begin : main_stim
        logic [15:0] i;
        int kind;
        ir = 16'h0000;
        reset = 1'b1;
        cyc(mk(4'h0));
        cyc(mk(4'h0));
        reset = 1'b0;
        cyc(fetch_e());

        run_instr(16'h0A53, 1'b0, 1'b0, 0);
        run_instr({7'h14, 9'h0}, 1'b1, 1'b0, 0);
        run_instr({7'h14, 9'h0}, 1'b0, 1'b0, 0);
        run_instr({7'h15, 9'h0}, 1'b1, 1'b0, 0);
        run_instr({7'h15, 9'h0}, 1'b0, 1'b0, 0);
        run_instr({7'h11, 3'd4, 3'd6, 3'd0}, 1'b0, 1'b0, 0);
        run_instr({7'h10, 3'd5, 3'd2, 3'd7}, 1'b0, 1'b1, 0);
        run_instr({7'h12, 3'd3, 3'd1, 3'd1}, 1'b1, 1'b0, 0);
        run_instr({7'h13, 9'h1AB}, 1'b0, 1'b0, 0);
        run_instr({7'h7F, 9'h0}, 1'b0, 1'b0, 20);
        run_instr({7'h20, 9'h0}, 1'b0, 1'b0, 4);

        for (int n = 0; n < 250; n++) begin
            kind = int'($urandom_range(0, 19));
            i = 16'($urandom);
            case (kind)
                0, 1, 2, 3, 4: i[15:9] = 7'($urandom_range(0, 15));
                5, 6:          i[15:9] = 7'h10;
                7, 8:          i[15:9] = 7'h11;
                9, 10:         i[15:9] = 7'h12;
                11:            i[15:9] = 7'h13;
                12, 13:        i[15:9] = 7'h14;
                14, 15:        i[15:9] = 7'h15;
                16:            i[15:9] = 7'h7F;
                17:            i[15:9] = 7'($urandom_range(7'h16, 7'h7E));
                default:       i[15:9] = 7'($urandom_range(0, 7'h13));
            endcase
            run_instr(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                      int'($urandom_range(1, 6)));
        end

        for (int k = 0; k < 200 && !nop_done; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        vectors++;
        if (!nop_done || q_main.size() != 0 || q_nop.size() != 0) begin
            miscompares++;
            $display("FAIL drain: nop_done=%0b main_left=%0d nop_left=%0d, want 1/0/0",
                     nop_done, q_main.size(), q_nop.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : nop_stim
        reset2 = 1'b1;
        ir2 = {7'h20, 9'h0};
        cyc2(mk(4'h0));
        cyc2(mk(4'h0));
        reset2 = 1'b0;
        cyc2(fetch_e());
        cyc2(mk(4'h2));
        cyc2(exec_e(ir2, 1'b0, 1'b0));
        ir2 = {7'h55, 9'h1FF};
        cyc2(mk(4'h2));
        cyc2(exec_e(ir2, 1'b0, 1'b0));
        ir2 = 16'h0A53;
        cyc2(mk(4'h2));
        cyc2(exec_e(ir2, 1'b0, 1'b0));
        cyc2(fetch_e());
        ir2 = {7'h7F, 9'h0};
        cyc2(mk(4'h2));
        repeat (3) cyc2(mk(4'hA));
        nop_done = 1'b1;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
